// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encoding, the counter
// step function and the gshare PHT index function.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_t;

    // gshare index at full width; callers size-cast down to their table width
    function automatic logic [31:0] pht_index(input logic [31:0] pc,
                                              input logic [31:0] ghr,
                                              input int unsigned idx_bits);
        logic [31:0] mask;
        mask = (32'd1 << idx_bits) - 32'd1;
        return ((pc >> 2) ^ ghr) & mask;
    endfunction

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            CTR_SN:  n = taken ? CTR_WN : CTR_SN;
            CTR_WN:  n = taken ? CTR_WT : CTR_SN;
            CTR_WT:  n = taken ? CTR_ST : CTR_WN;
            CTR_ST:  n = taken ? CTR_ST : CTR_WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of 2-bit saturating counters: combinational read port, one
// registered update port, all counters reset to weakly-not-taken.
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    localparam int DEPTH = 1 << IDX_W;

    ctr_t tbl [DEPTH];

    // Read sees pre-edge contents, so a same-cycle update is not forwarded
    assign rd_ctr = tbl[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_WN;
        end else if (upd_en) begin
            tbl[upd_idx] <= ctr_next(tbl[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage predictor: fully associative BTB for targets plus a gshare
// PHT for direction, with non-speculative global history updated at EXEC.
module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int HIST_BITS = 4,
    parameter int PHT_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_valid,
    input  logic [31:0]          f_pc,
    output logic [31:0]          f_predict_addr,
    output logic                 f_predict_valid,
    output logic                 f_hit,
    output logic [HIST_BITS-1:0] f_ghr,
    input  logic                 d_is_branch,
    input  logic [31:0]          d_pc,
    input  logic [31:0]          d_target_addr,
    input  logic                 x_valid,
    input  logic [31:0]          x_pc,
    input  logic                 x_taken,
    input  logic [HIST_BITS-1:0] x_ghr
);
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0]       btb_valid;
    logic [ENTRIES-1:0][31:0] btb_tag;
    logic [ENTRIES-1:0][31:0] btb_tgt;
    logic [PTR_W-1:0]         rpl_ptr;
    logic [HIST_BITS-1:0]     ghr;

    logic [ENTRIES-1:0] f_hit_vec;
    logic [ENTRIES-1:0] d_hit_vec;
    logic               f_hit_any;
    logic               d_hit_any;
    logic [31:0]        f_tgt;
    logic [PTR_W-1:0]   d_idx;
    logic [PHT_BITS-1:0] rd_idx;
    logic [PHT_BITS-1:0] upd_idx;
    ctr_t               rd_ctr;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cmp
        assign f_hit_vec[i] = btb_valid[i] && (btb_tag[i] == f_pc);
        assign d_hit_vec[i] = btb_valid[i] && (btb_tag[i] == d_pc);
    end

    // Tags are unique, so at most one bit of each hit vector is set
    always_comb begin
        f_tgt = '0;
        d_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (f_hit_vec[i]) f_tgt = f_tgt | btb_tgt[i];
            if (d_hit_vec[i]) d_idx = PTR_W'(i);
        end
    end

    assign f_hit_any = |f_hit_vec;
    assign d_hit_any = |d_hit_vec;

    assign rd_idx  = PHT_BITS'(pht_index(f_pc, 32'(ghr), PHT_BITS));
    assign upd_idx = PHT_BITS'(pht_index(x_pc, 32'(x_ghr), PHT_BITS));

    sat_counter_table #(.IDX_W(PHT_BITS)) u_pht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (rd_idx),
        .rd_ctr    (rd_ctr),
        .upd_en    (x_valid),
        .upd_idx   (upd_idx),
        .upd_taken (x_taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_hit           <= 1'b0;
            f_predict_valid <= 1'b0;
            f_predict_addr  <= '0;
            f_ghr           <= '0;
        end else if (f_valid) begin
            f_hit           <= f_hit_any;
            f_predict_valid <= f_hit_any && rd_ctr[1];
            f_predict_addr  <= f_tgt;
            f_ghr           <= ghr;
        end else begin
            f_hit           <= 1'b0;
            f_predict_valid <= 1'b0;
        end
    end

    // Decode retargets an existing entry or allocates round-robin on a miss
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid <= '0;
            btb_tag   <= '0;
            btb_tgt   <= '0;
            rpl_ptr   <= '0;
        end else if (d_is_branch) begin
            if (d_hit_any) begin
                btb_tgt[d_idx] <= d_target_addr;
            end else begin
                btb_valid[rpl_ptr] <= 1'b1;
                btb_tag[rpl_ptr]   <= d_pc;
                btb_tgt[rpl_ptr]   <= d_target_addr;
                rpl_ptr <= (rpl_ptr == PTR_W'(ENTRIES - 1)) ? '0 : rpl_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (x_valid) begin
            ghr <= HIST_BITS'({ghr, x_taken});
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor with a behavioural reference model
// and a per-cycle compare process.
module tb_gshare_btb_predictor;
    localparam int ENTRIES   = 8;
    localparam int HIST_BITS = 4;
    localparam int PHT_BITS  = 6;
    localparam int PHT_SIZE  = 1 << PHT_BITS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 f_valid;
    logic [31:0]          f_pc;
    logic [31:0]          f_predict_addr;
    logic                 f_predict_valid;
    logic                 f_hit;
    logic [HIST_BITS-1:0] f_ghr;
    logic                 d_is_branch;
    logic [31:0]          d_pc;
    logic [31:0]          d_target_addr;
    logic                 x_valid;
    logic [31:0]          x_pc;
    logic                 x_taken;
    logic [HIST_BITS-1:0] x_ghr;

    always #5 clk = ~clk;

    gshare_btb_predictor #(.ENTRIES(ENTRIES), .HIST_BITS(HIST_BITS), .PHT_BITS(PHT_BITS)) dut (
        .clk(clk), .reset(reset),
        .f_valid(f_valid), .f_pc(f_pc),
        .f_predict_addr(f_predict_addr), .f_predict_valid(f_predict_valid),
        .f_hit(f_hit), .f_ghr(f_ghr),
        .d_is_branch(d_is_branch), .d_pc(d_pc), .d_target_addr(d_target_addr),
        .x_valid(x_valid), .x_pc(x_pc), .x_taken(x_taken), .x_ghr(x_ghr)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ptr;
    int          m_ctr   [PHT_SIZE];
    int          m_ghr;

    // expected outputs after the most recent edge
    bit          e_hit, e_pv, e_addr_ok;
    logic [31:0] e_addr;
    int          e_ghr;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [31:0] pc);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    function automatic int pidx(input logic [31:0] pc, input int g);
        return int'(((pc / 4) ^ 32'(g)) % PHT_SIZE);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < PHT_SIZE; i++) m_ctr[i] = 1;
        m_ptr = 0;
        m_ghr = 0;
    endtask

    // Evaluate the model on the current inputs, then advance one clock
    task automatic tick();
        bit nh, np, nao;
        logic [31:0] na;
        int ng, h, k;
        nh = 1'b0; np = 1'b0; na = e_addr; nao = e_addr_ok; ng = e_ghr;
        if (reset) begin
            model_reset();
            na = '0; nao = 1'b1; ng = 0;
        end else begin
            if (f_valid) begin
                h   = find(f_pc);
                nh  = (h >= 0);
                np  = nh && (m_ctr[pidx(f_pc, m_ghr)] >= 2);
                ng  = m_ghr;
                nao = nh;
                na  = nh ? m_tgt[h] : 32'h0;
            end
            if (d_is_branch) begin
                h = find(d_pc);
                if (h >= 0) m_tgt[h] = d_target_addr;
                else begin
                    m_valid[m_ptr] = 1'b1;
                    m_tag[m_ptr]   = d_pc;
                    m_tgt[m_ptr]   = d_target_addr;
                    m_ptr = (m_ptr + 1) % ENTRIES;
                end
            end
            if (x_valid) begin
                k = pidx(x_pc, int'(x_ghr));
                if (x_taken) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                else         m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                m_ghr = ((m_ghr * 2) + int'(x_taken)) % (1 << HIST_BITS);
            end
        end
        @(posedge clk);
        #1;
        e_hit = nh; e_pv = np; e_addr = na; e_addr_ok = nao; e_ghr = ng;
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("f_hit", 32'(f_hit), 32'(e_hit));
            check("f_predict_valid", 32'(f_predict_valid), 32'(e_pv));
            check("f_ghr", 32'(f_ghr), 32'(e_ghr));
            if (e_addr_ok) check("f_predict_addr", f_predict_addr, e_addr);
        end
    end

    task automatic idle();
        f_valid = 1'b0; d_is_branch = 1'b0; x_valid = 1'b0;
    endtask

    // Asynchronous assertion: outputs must clear before any clock edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("async_hit", 32'(f_hit), 32'h0);
        check("async_pv", 32'(f_predict_valid), 32'h0);
        check("async_addr", f_predict_addr, 32'h0);
        check("async_ghr", 32'(f_ghr), 32'h0);
        model_reset();
        e_hit = 1'b0; e_pv = 1'b0; e_addr = '0; e_addr_ok = 1'b1; e_ghr = 0;
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic insert(input logic [31:0] pc, input logic [31:0] tgt);
        idle();
        d_is_branch = 1'b1; d_pc = pc; d_target_addr = tgt;
        tick();
        idle();
    endtask

    task automatic exec(input logic [31:0] pc, input logic taken, input logic [HIST_BITS-1:0] g);
        idle();
        x_valid = 1'b1; x_pc = pc; x_taken = taken; x_ghr = g;
        tick();
        idle();
    endtask

    task automatic lookup_expect(input logic [31:0] pc, input logic h, input logic p);
        idle();
        f_valid = 1'b1; f_pc = pc;
        tick();
        check("lit_hit", 32'(f_hit), 32'(h));
        check("lit_pv", 32'(f_predict_valid), 32'(p));
        idle();
    endtask

    initial begin
        reset = 1'b1;
        f_pc = '0; d_pc = '0; d_target_addr = '0; x_pc = '0; x_taken = 1'b0; x_ghr = '0;
        idle();
        do_reset();

        // cold lookup misses with empty history
        lookup_expect(32'h100, 1'b0, 1'b0);
        check("lit_ghr_cold", 32'(f_ghr), 32'h0);

        // two taken updates on the lookup index make it strongly taken
        insert(32'h100, 32'h200);
        exec(32'h100, 1'b1, 4'd3);
        exec(32'h100, 1'b1, 4'd3);
        lookup_expect(32'h100, 1'b1, 1'b1);
        check("lit_addr_200", f_predict_addr, 32'h200);
        check("lit_ghr_3", 32'(f_ghr), 32'h3);

        // decode hit retargets without allocating
        insert(32'h100, 32'h240);
        lookup_expect(32'h100, 1'b1, 1'b1);
        check("lit_addr_240", f_predict_addr, 32'h240);

        // same-cycle insert and lookup: lookup misses
        idle();
        d_is_branch = 1'b1; d_pc = 32'h500; d_target_addr = 32'h5A0;
        f_valid = 1'b1; f_pc = 32'h500;
        tick();
        check("lit_same_cycle_insert", 32'(f_hit), 32'h0);
        lookup_expect(32'h500, 1'b1, 1'b1);
        check("lit_addr_5a0", f_predict_addr, 32'h5A0);

        // decode and exec in the same cycle
        idle();
        d_is_branch = 1'b1; d_pc = 32'h600; d_target_addr = 32'h6A0;
        x_valid = 1'b1; x_pc = 32'h84; x_taken = 1'b0; x_ghr = 4'd0;
        tick();
        lookup_expect(32'h600, 1'b1, 1'b0);
        check("lit_addr_6a0", f_predict_addr, 32'h6A0);
        check("lit_ghr_6", 32'(f_ghr), 32'h6);

        // capacity: nine inserts into eight entries evict the first
        do_reset();
        for (int k = 0; k < 9; k++) insert(32'(k * 4), 32'h1000 + 32'(k * 4));
        for (int k = 0; k < 9; k++) lookup_expect(32'(k * 4), (k != 0), 1'b0);

        // counter saturates at strongly-not-taken, then steps to weakly-not-taken
        insert(32'h104, 32'h1104);
        for (int k = 0; k < 5; k++) exec(32'h104, 1'b0, 4'd0);
        check("pin_ctr_floor", 32'(m_ctr[1]), 32'h0);
        lookup_expect(32'h104, 1'b1, 1'b0);
        exec(32'h104, 1'b1, 4'd0);
        for (int k = 0; k < 4; k++) exec(32'h84, 1'b0, 4'd0);
        check("pin_ctr_wn", 32'(m_ctr[1]), 32'h1);
        lookup_expect(32'h104, 1'b1, 1'b0);

        // history 1,0,1,1 from reset
        do_reset();
        exec(32'h84, 1'b1, 4'd0);
        exec(32'h84, 1'b0, 4'd0);
        exec(32'h84, 1'b1, 4'd0);
        exec(32'h84, 1'b1, 4'd0);
        lookup_expect(32'h700, 1'b0, 1'b0);
        check("lit_ghr_1011", 32'(f_ghr), 32'hB);
        check("pin_model_ghr", 32'(m_ghr), 32'hB);

        // same-cycle counter update and lookup: lookup sees old counter
        insert(32'h100, 32'h200);
        idle();
        f_valid = 1'b1; f_pc = 32'h100;
        x_valid = 1'b1; x_pc = 32'h100; x_taken = 1'b1; x_ghr = 4'd11;
        tick();
        check("lit_same_cycle_ctr_hit", 32'(f_hit), 32'h1);
        check("lit_same_cycle_ctr_pv", 32'(f_predict_valid), 32'h0);
        exec(32'h84, 1'b1, 4'd0);
        exec(32'h84, 1'b0, 4'd0);
        exec(32'h84, 1'b1, 4'd0);
        exec(32'h84, 1'b1, 4'd0);
        lookup_expect(32'h100, 1'b1, 1'b1);

        // reset between inserts discards the concurrent decode and exec
        insert(32'h300, 32'h3A0);
        idle();
        d_is_branch = 1'b1; d_pc = 32'h304; d_target_addr = 32'h3A4;
        x_valid = 1'b1; x_pc = 32'h84; x_taken = 1'b1; x_ghr = 4'd0;
        do_reset();
        lookup_expect(32'h300, 1'b0, 1'b0);
        lookup_expect(32'h304, 1'b0, 1'b0);
        check("lit_ghr_after_reset", 32'(f_ghr), 32'h0);
        insert(32'h308, 32'h3B0);
        lookup_expect(32'h308, 1'b1, 1'b0);
        check("lit_addr_3b0", f_predict_addr, 32'h3B0);
        for (int k = 0; k < 8; k++) insert(32'h400 + 32'(k * 4), 32'h2000 + 32'(k * 4));
        lookup_expect(32'h308, 1'b0, 1'b0);
        lookup_expect(32'h400, 1'b1, 1'b0);

        idle();
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_btb_predictor.md
GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

Interface
REQ-001 Parameter ENTRIES, default 8, number of BTB entries; power of two, 2..64.
REQ-002 Parameter HIST_BITS, default 4, global history length; 1..PHT_BITS.
REQ-003 Parameter PHT_BITS, default 6, PHT index width; table holds 2^PHT_BITS 2-bit counters.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 f_valid  in  1  fetch lookup request.
REQ-007 f_pc  in  32  fetch address to predict.
REQ-008 f_predict_addr  out  32  predicted target, registered.
REQ-009 f_predict_valid  out  1  BTB hit AND counter predicts taken, registered.
REQ-010 f_hit  out  1  BTB hit regardless of direction, registered.
REQ-011 f_ghr  out  HIST_BITS  GHR value used for this lookup, carried down the pipeline, registered.
REQ-012 d_is_branch  in  1  decoded instruction is a branch.
REQ-013 d_pc  in  32  PC of decoded branch.
REQ-014 d_target_addr  in  32  decoded branch target.
REQ-015 x_valid  in  1  branch resolved in EXEC this cycle.
REQ-016 x_pc  in  32  PC of resolved branch.
REQ-017 x_taken  in  1  actual branch outcome.
REQ-018 x_ghr  in  HIST_BITS  f_ghr snapshot returned with the resolved branch.

Function
REQ-019 Lookup latency SHALL be one cycle: f_valid/f_pc sampled at edge N drive outputs after edge N+1; if f_valid=0, f_hit and f_predict_valid SHALL be 0 after the edge, f_predict_addr holds.
REQ-020 BTB SHALL be fully associative; each entry holds valid bit, full 32-bit tag PC, 32-bit target; hit = valid AND tag==f_pc.
REQ-021 PHT index SHALL be pc[PHT_BITS+1:2] XOR zero-extended GHR (gshare); lookup uses current GHR, update uses x_ghr.
REQ-022 f_predict_valid SHALL equal hit AND counter[1] (10/11 taken).
REQ-023 On d_is_branch with d_pc hit: target field SHALL be overwritten with d_target_addr, no allocation.
REQ-024 On d_is_branch with d_pc miss: entry at replacement pointer SHALL be written (valid=1, tag, target) and pointer SHALL increment, wrapping ENTRIES-1 to 0; no duplicate tags ever.
REQ-025 On x_valid: indexed counter SHALL increment if x_taken else decrement, saturating at 11 and 00.
REQ-026 On x_valid: GHR SHALL shift left inserting x_taken at bit 0, MSB discarded (non-speculative history).
REQ-027 Same-cycle insert and lookup of same PC: lookup SHALL see pre-edge state (miss).
REQ-028 Same-cycle counter update and lookup of same PHT index: lookup SHALL see pre-update counter.
REQ-029 Decode and EXEC activity in same cycle SHALL both take effect independently.
REQ-030 PHT SHALL NOT be reset on BTB allocation.

Reset
REQ-031 While reset=1: all BTB valid bits 0, all counters 01, GHR 0, replacement pointer 0, f_hit/f_predict_valid/f_predict_addr/f_ghr 0, immediately, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard any same-cycle decode or EXEC update; first lookup after deassertion SHALL miss.

Structure
REQ-033 Counter encodings (SN=00, WN=01, WT=10, ST=11) and the PHT index function SHALL live in shared package bp_pkg.
REQ-034 PHT SHALL be sub-module sat_counter_table (one read port, one saturating update port, async reset to WN).

Verification
REQ-035 Reset, then f_pc=0x100 f_valid=1 -> next cycle f_hit=0, f_predict_valid=0, f_ghr=0.
REQ-036 d_is_branch d_pc=0x100 target=0x200; two x_valid taken with x_ghr matching lookup -> lookup 0x100 yields f_hit=1, f_predict_addr=0x200, f_predict_valid=1.
REQ-037 ENTRIES=8: insert 9 distinct PCs 0x000..0x020 step 4 -> 0x000 misses, 0x004..0x020 hit.
REQ-038 Four x_valid not-taken on same index -> counter 00, fifth does not underflow; then one taken -> 01, f_predict_valid=0.
REQ-039 x_taken sequence 1,0,1,1 from reset, HIST_BITS=4 -> f_ghr=4'b1011.
REQ-040 Assert reset between two decode inserts -> after release BTB empty, pointer 0, next insert lands in entry 0.
